dcache_line_ctrl: RTL and testbench
===================================

Name: dcache_line_ctrl

Overview:
- Upstream controller for the cache bus unit.
- Accepts CPU load/store requests and holds a direct-mapped, write-back tag/valid/dirty array.
- Drives the external single-port data SSRAM.
- On a miss, sequences the bus unit: write back the victim line, then refill the new line. Uncacheable accesses go through the bus unit's single read / write-through requests.
- Line geometry is fixed at 2048 B (256 beats x 64 bit), matching the bus unit's 8-bit beat counter.

Parameters:
- SETS, 16: number of lines; power of 2, 2..64. INDEX_W = log2(SETS).
- SRAM_AW, 8+INDEX_W: data SSRAM word-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store
- req_cacheable  in  1  0 = bypass cache
- req_size  in  4  one-hot: [0]=1B, [1]=2B, [2]=4B, [3]=8B
- req_addr  in  64  physical address
- req_wdata  in  64  store data, lane-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  bus error, qualified by resp_valid
- resp_rdata  out  64  load data, full 64-bit word
- write_through_req, read_req, read_line_req, write_line_req  out  1  requests to the bus unit
- size  out  4  registered req_size
- pa  out  64  bus address
- wt_data  out  64  store data / write-back data
- line_data  in  64  refill beat
- addr_count  in  11  byte offset of the current beat
- line_write  in  1  refill beat valid
- trans_rdy  in  1  transfer done
- bus_error  in  1  access fault
- sram_addr  out  SRAM_AW  data SSRAM address
- sram_we  out  1  SSRAM write strobe
- sram_be  out  8  SSRAM byte enables
- sram_wdata  out  64  SSRAM write data
- sram_rdata  in  64  SSRAM read data, 1-cycle read latency

Behaviour:
- Address split: offset = addr[10:3], index = addr[11+INDEX_W-1:11], tag = addr[63:11+INDEX_W].
- Reset (async, rst_n low): state IDLE; all valid and dirty bits 0; all bus requests 0; sram_we 0; resp_valid 0; resp_err 0; req_ready 1; resp_rdata 0.
- Accept: req_valid & req_ready in IDLE. Addr, size, wdata, we and cacheable are registered; req_ready drops to 0 until the cycle after resp_valid.
- LOOKUP (1 cycle): hit = valid[idx] & tag match & cacheable.
  - Hit load: sram_addr = {idx, offset}; go to RDATA. resp_valid and resp_rdata = sram_rdata on the next cycle (2 cycles after accept).
  - Hit store: sram_we = 1 with sram_be from size and addr[2:0]; set dirty[idx]; go to RESP (resp_valid 2 cycles after accept).
  - Miss, dirty victim: go to WB. Miss, clean victim: go to RF.
  - Uncacheable load: go to UNC_RD. Uncacheable store: go to UNC_WR.
- WB: write_line_req held 1 until trans_rdy.
  - pa = {victim tag, idx, 11'b0}.
  - sram_addr = {idx, addr_count[10:3]}; wt_data = sram_rdata.
  - On trans_rdy: clear dirty[idx], go to RF.
- RF: read_line_req held 1 until trans_rdy.
  - pa = {tag, idx, 11'b0}.
  - On each line_write: sram_we = 1, sram_be = 8'hFF, sram_addr = {idx, addr_count[10:3]}, sram_wdata = line_data.
  - On trans_rdy: set valid[idx], load the new tag, dirty = 0; go back to LOOKUP (replay, which now hits).
- UNC_RD: read_req, pa = req_addr. On trans_rdy: resp_rdata = line_data, resp_valid.
- UNC_WR: write_through_req, pa = req_addr, wt_data = req_wdata. On trans_rdy: resp_valid.
- ERR: bus_error in any bus state → resp_valid = 1 and resp_err = 1 next cycle.
  - Refill error: valid[idx] = 0.
  - Write-back error: dirty stays 1 and the line stays valid.
  - Return to IDLE.
- Exactly one bus request is high at a time. Requests stay high through the cycle trans_rdy/bus_error is seen, then drop.
- sram_we is never asserted in WB, UNC_RD, UNC_WR, ERR or IDLE.
- Store byte enables: 1B → one bit at addr[2:0]; 2B → 2 bits at addr[2:1]*2; 4B → 4 bits at addr[2]*4; 8B → 8'hFF. Misaligned lanes are truncated within the word and never wrap.
- Reset mid-operation aborts everything immediately, and all lines become invalid. Software must flush before asserting reset; no write-back is attempted.

Decomposition:
- Package dcache_pkg:
  - State encoding: IDLE, LOOKUP, RDATA, RESP, WB, RF, UNC_RD, UNC_WR, ERR.
  - Size one-hot constants.
  - LINE_BEATS = 256.
  - Function size_to_be(size, addr[2:0]) → 8-bit enables.
- Sub-module dcache_tag_array: SETS entries of {valid, dirty, tag}, async read, sync write, async clear on rst_n.

Test Plan:
- Reset, then load 0x8000 (cacheable, empty cache) → read_line_req with pa = 0x8000, 256 line_write SRAM writes at addresses {0, 0..255}, replay hit, resp_valid with data of beat 0.
- Repeat load 0x8008 → no bus request; resp_valid exactly 2 cycles after accept with beat-1 data.
- Store 1B 0xAB to 0x8003 → sram_be = 8'h08, dirty[0] = 1, no bus activity; load 0x8000 returns byte 3 = 0xAB.
- Load 0x10000 (same index 0, SETS = 16) with the line dirty → write_line_req with pa = 0x8000 and wt_data tracking SRAM beats, then read_line_req with pa = 0x10000; dirty = 0.
- Uncacheable store 4B to 0xF000_0004 → write_through_req only, wt_data = req_wdata, no SRAM write, resp_valid after trans_rdy.
- Refill of 0x20000 with bus_error at beat 100 → resp_err = 1; valid[0] = 0; a subsequent load to 0x20000 misses and refills again.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, constants and helpers for the data-cache line controller
package dcache_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        RDATA,
        RESP,
        WB,
        RF,
        UNC_RD,
        UNC_WR,
        ERR
    } state_t;

    localparam logic [3:0] SIZE_1B = 4'b0001;
    localparam logic [3:0] SIZE_2B = 4'b0010;
    localparam logic [3:0] SIZE_4B = 4'b0100;
    localparam logic [3:0] SIZE_8B = 4'b1000;

    localparam int LINE_BEATS = 256;

    // Lane base is aligned down to the access size, so the mask never spills past byte 7.
    function automatic logic [7:0] size_to_be(input logic [3:0] sz, input logic [2:0] lane);
        logic [7:0] be;
        case (sz)
            SIZE_1B: be = 8'h01 << lane;
            SIZE_2B: be = 8'h03 << {lane[2:1], 1'b0};
            SIZE_4B: be = 8'h0F << {lane[2], 2'b00};
            SIZE_8B: be = 8'hFF;
            default: be = 8'h00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// rtl/dcache_tag_array.sv - direct-mapped valid/dirty/tag store, async read, sync write
module dcache_tag_array #(
    parameter int SETS    = 16,
    parameter int INDEX_W = $clog2(SETS),
    parameter int TAG_W   = 64 - 11 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               wr_en,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic [TAG_W-1:0]   wr_tag
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= wr_valid;
            dirty_q[idx] <= wr_dirty;
        end
    end

    // Tags are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];

endmodule

// File: rtl/dcache_line_ctrl.sv
// rtl/dcache_line_ctrl.sv - write-back direct-mapped cache controller in front of the cache bus unit
module dcache_line_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS    = 16,
    parameter int SRAM_AW = 8 + $clog2(SETS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic               req_cacheable,
    input  logic [3:0]         req_size,
    input  logic [63:0]        req_addr,
    input  logic [63:0]        req_wdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [63:0]        resp_rdata,
    output logic               write_through_req,
    output logic               read_req,
    output logic               read_line_req,
    output logic               write_line_req,
    output logic [3:0]         size,
    output logic [63:0]        pa,
    output logic [63:0]        wt_data,
    input  logic [63:0]        line_data,
    input  logic [10:0]        addr_count,
    input  logic               line_write,
    input  logic               trans_rdy,
    input  logic               bus_error,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we,
    output logic [7:0]         sram_be,
    output logic [63:0]        sram_wdata,
    input  logic [63:0]        sram_rdata
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 64 - 11 - INDEX_W;
    localparam int BEAT_W  = $clog2(LINE_BEATS);

    state_t state_q, state_d;

    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  size_q;
    logic        we_q, cacheable_q;

    logic [INDEX_W-1:0] idx;
    logic [BEAT_W-1:0]  offset, beat;
    logic [TAG_W-1:0]   tag;

    logic               ent_valid, ent_dirty, hit;
    logic [TAG_W-1:0]   ent_tag;
    logic               tag_we, tag_wr_valid, tag_wr_dirty;
    logic [TAG_W-1:0]   tag_wr_tag;

    logic unused_bits;
    assign unused_bits = ^addr_count[2:0];

    assign idx    = addr_q[11+INDEX_W-1:11];
    assign offset = addr_q[10:3];
    assign tag    = addr_q[63:11+INDEX_W];
    assign beat   = addr_count[10:3];

    dcache_tag_array #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (idx),
        .rd_valid (ent_valid),
        .rd_dirty (ent_dirty),
        .rd_tag   (ent_tag),
        .wr_en    (tag_we),
        .wr_valid (tag_wr_valid),
        .wr_dirty (tag_wr_dirty),
        .wr_tag   (tag_wr_tag)
    );

    assign hit = ent_valid && (ent_tag == tag) && cacheable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            cacheable_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                size_q      <= req_size;
                we_q        <= req_we;
                cacheable_q <= req_cacheable;
            end
            if (state_q == UNC_RD && trans_rdy && !bus_error) begin
                rdata_q <= line_data;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sram_we      = 1'b0;
        sram_be      = 8'h00;
        sram_addr    = {idx, offset};
        sram_wdata   = wdata_q;
        tag_we       = 1'b0;
        tag_wr_valid = ent_valid;
        tag_wr_dirty = ent_dirty;
        tag_wr_tag   = ent_tag;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!cacheable_q) begin
                    state_d = we_q ? UNC_WR : UNC_RD;
                end else if (hit && we_q) begin
                    sram_we      = 1'b1;
                    sram_be      = size_to_be(size_q, addr_q[2:0]);
                    tag_we       = 1'b1;
                    tag_wr_dirty = 1'b1;
                    state_d      = RESP;
                end else if (hit) begin
                    state_d = RDATA;
                end else if (ent_valid && ent_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = RF;
                end
            end
            WB: begin
                sram_addr = {idx, beat};
                // A failed write-back leaves the victim valid and dirty so nothing is lost.
                if (bus_error) begin
                    state_d = ERR;
                end else if (trans_rdy) begin
                    tag_we       = 1'b1;
                    tag_wr_dirty = 1'b0;
                    state_d      = RF;
                end
            end
            RF: begin
                if (line_write) begin
                    sram_we    = 1'b1;
                    sram_be    = 8'hFF;
                    sram_addr  = {idx, beat};
                    sram_wdata = line_data;
                end
                if (bus_error) begin
                    tag_we       = 1'b1;
                    tag_wr_valid = 1'b0;
                    tag_wr_dirty = 1'b0;
                    state_d      = ERR;
                end else if (trans_rdy) begin
                    tag_we       = 1'b1;
                    tag_wr_valid = 1'b1;
                    tag_wr_dirty = 1'b0;
                    tag_wr_tag   = tag;
                    state_d      = LOOKUP;
                end
            end
            UNC_RD, UNC_WR: begin
                if (bus_error)      state_d = ERR;
                else if (trans_rdy) state_d = RESP;
            end
            RDATA, RESP, ERR: state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    assign req_ready         = (state_q == IDLE);
    assign resp_valid        = (state_q == RDATA) || (state_q == RESP) || (state_q == ERR);
    assign resp_err          = (state_q == ERR);
    assign resp_rdata        = (state_q == RDATA) ? sram_rdata : rdata_q;
    assign write_line_req    = (state_q == WB);
    assign read_line_req     = (state_q == RF);
    assign read_req          = (state_q == UNC_RD);
    assign write_through_req = (state_q == UNC_WR);
    assign size              = size_q;
    assign wt_data           = (state_q == WB) ? sram_rdata : wdata_q;

    always_comb begin
        pa = addr_q;
        if (state_q == WB) begin
            pa = {ent_tag, idx, 11'b0};
        end else if (state_q == RF) begin
            pa = {tag, idx, 11'b0};
        end
    end

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// tb/tb_dcache_line_ctrl.sv - directed self-checking bench for dcache_line_ctrl
module tb_dcache_line_ctrl;

    localparam logic [3:0] SZ1 = 4'b0001;
    localparam logic [3:0] SZ2 = 4'b0010;
    localparam logic [3:0] SZ4 = 4'b0100;
    localparam logic [3:0] SZ8 = 4'b1000;
    localparam logic [15:0] S1 = 16'h1111;
    localparam logic [15:0] S2 = 16'h2222;
    localparam logic [15:0] S3 = 16'h3333;
    localparam logic [15:0] S4 = 16'h4444;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_cacheable = 1'b0;
    logic [3:0]  req_size = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        write_through_req, read_req, read_line_req, write_line_req;
    logic [3:0]  size;
    logic [63:0] pa, wt_data;
    logic [63:0] line_data = '0;
    logic [10:0] addr_count = '0;
    logic        line_write = 1'b0, trans_rdy = 1'b0, bus_error = 1'b0;
    logic [11:0] sram_addr;
    logic        sram_we;
    logic [7:0]  sram_be;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int multi  = 0;

    logic [63:0] mem [4096];
    logic [63:0] exp_line [256];

    typedef struct {
        logic        we;
        logic [3:0]  sz;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] rdata;
    } vec_t;
    vec_t vecs [12];

    dcache_line_ctrl #(.SETS(16), .SRAM_AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_cacheable(req_cacheable), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .write_through_req(write_through_req),
        .read_req(read_req), .read_line_req(read_line_req),
        .write_line_req(write_line_req), .size(size), .pa(pa), .wt_data(wt_data),
        .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
        .trans_rdy(trans_rdy), .bus_error(bus_error), .sram_addr(sram_addr),
        .sram_we(sram_we), .sram_be(sram_be), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int j = 0; j < 8; j++) begin
            if (sram_we && sram_be[j]) mem[sram_addr][j*8 +: 8] <= sram_wdata[j*8 +: 8];
        end
        sram_rdata <= mem[sram_addr];
    end

    always @(negedge clk) begin
        if (rst_n && $countones({read_line_req, write_line_req, read_req, write_through_req}) > 1) multi++;
        if (rst_n && sram_we && (write_line_req || read_req || write_through_req)) multi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] beat(input logic [15:0] seed, input int i);
        logic [7:0] b;
        b = i[7:0];
        return {seed, 8'h00, b, seed ^ 16'h5A5A, b, 8'h3C};
    endfunction

    function automatic vec_t mk(input logic we, input logic [3:0] sz, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] be, input logic [63:0] rdata);
        vec_t v;
        v.we = we; v.sz = sz; v.addr = addr; v.wdata = wdata; v.be = be; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic cacheable, input logic [3:0] sz,
                         input logic [63:0] addr, input logic [63:0] wdata);
        bit rdy = 0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = req_ready;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL req_ready actual=timeout required=asserted");
        end
        req_valid = 1'b1; req_we = we; req_cacheable = cacheable;
        req_size = sz; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_sig(input int code, input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            case (code)
                0: seen = read_line_req;
                1: seen = write_line_req;
                2: seen = read_req;
                3: seen = write_through_req;
                default: seen = resp_valid;
            endcase
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s actual=timeout required=asserted", name);
        end
    endtask

    task automatic refill(input logic [15:0] seed, input int err_beat, input string name);
        int bad = 0;
        int n = (err_beat >= 0) ? err_beat : 256;
        for (int b = 0; b < n; b++) begin
            @(posedge clk); #1;
            line_write = 1'b1; addr_count = 11'(b * 8); line_data = beat(seed, b);
            @(negedge clk);
            if (sram_we !== 1'b1 || sram_be !== 8'hFF || sram_addr !== 12'(b) ||
                sram_wdata !== beat(seed, b) || read_line_req !== 1'b1) bad++;
        end
        @(posedge clk); #1;
        line_write = 1'b0;
        if (err_beat >= 0) bus_error = 1'b1;
        else               trans_rdy = 1'b1;
        @(negedge clk);
        chk({name, "_req_held"}, read_line_req, 1);
        @(posedge clk); #1;
        bus_error = 1'b0; trans_rdy = 1'b0;
        chk({name, "_beats_bad"}, bad, 0);
    endtask

    task automatic expect_resp(input string name, input logic [63:0] rdata);
        wait_sig(4, {name, "_resp"});
        chk({name, "_err"}, resp_err, 0);
        chk({name, "_rdata"}, resp_rdata, rdata);
    endtask

    task automatic run_hit(input vec_t v, input int n);
        int busy = 0;
        issue(v.we, 1'b1, v.sz, v.addr, v.wdata);
        @(negedge clk);
        busy += int'(read_line_req | write_line_req | read_req | write_through_req);
        chk($sformatf("v%0d_early_resp", n), resp_valid, 0);
        chk($sformatf("v%0d_sram_we", n), sram_we, v.we);
        if (v.we) chk($sformatf("v%0d_sram_be", n), sram_be, v.be);
        @(negedge clk);
        busy += int'(read_line_req | write_line_req | read_req | write_through_req);
        chk($sformatf("v%0d_resp_2cyc", n), resp_valid, 1);
        chk($sformatf("v%0d_resp_err", n), resp_err, 0);
        if (!v.we) chk($sformatf("v%0d_rdata", n), resp_rdata, v.rdata);
        chk($sformatf("v%0d_no_bus", n), busy, 0);
    endtask

    initial begin
        int bad;

        vecs[0]  = mk(0, SZ8, 64'h8008, 64'h0, 8'h00, beat(S1, 1));
        vecs[1]  = mk(1, SZ1, 64'h8003, 64'hFFFF_FFFF_ABFF_FFFF, 8'h08, 64'h0);
        vecs[2]  = mk(0, SZ8, 64'h8000, 64'h0, 8'h00,
                      (beat(S1, 0) & ~64'h0000_0000_FF00_0000) | 64'h0000_0000_AB00_0000);
        vecs[3]  = mk(1, SZ2, 64'h8016, 64'hBEEF_FFFF_FFFF_FFFF, 8'hC0, 64'h0);
        vecs[4]  = mk(0, SZ8, 64'h8010, 64'h0, 8'h00,
                      (beat(S1, 2) & 64'h0000_FFFF_FFFF_FFFF) | 64'hBEEF_0000_0000_0000);
        vecs[5]  = mk(1, SZ4, 64'h8024, 64'hDEAD_BEEF_1234_5678, 8'hF0, 64'h0);
        vecs[6]  = mk(0, SZ8, 64'h8020, 64'h0, 8'h00,
                      (beat(S1, 4) & 64'h0000_0000_FFFF_FFFF) | 64'hDEAD_BEEF_0000_0000);
        vecs[7]  = mk(1, SZ8, 64'h8038, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0);
        vecs[8]  = mk(0, SZ8, 64'h8038, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
        vecs[9]  = mk(1, SZ2, 64'h8047, 64'h5A5A_0000_0000_0000, 8'hC0, 64'h0);
        vecs[10] = mk(0, SZ8, 64'h8040, 64'h0, 8'h00,
                      (beat(S1, 8) & 64'h0000_FFFF_FFFF_FFFF) | 64'h5A5A_0000_0000_0000);
        vecs[11] = mk(0, SZ8, 64'h87F8, 64'h0, 8'h00, beat(S1, 255));
        for (int i = 0; i < 256; i++) exp_line[i] = beat(S1, i);

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_bus_reqs", {read_line_req, write_line_req, read_req, write_through_req}, 0);
        chk("rst_sram_we", sram_we, 0);
        rst_n = 1'b1;

        issue(0, 1, SZ8, 64'h8000, 64'h0);
        wait_sig(0, "rf1_req");
        chk("rf1_pa", pa, 64'h8000);
        chk("rf1_no_wb", write_line_req, 0);
        refill(S1, -1, "rf1");
        expect_resp("rf1", beat(S1, 0));

        for (int i = 0; i < 12; i++) begin
            run_hit(vecs[i], i);
            if (!vecs[i].we) exp_line[vecs[i].addr[10:3]] = vecs[i].rdata;
        end
        chk("dirty_after_store", dut.u_tags.dirty_q[0], 1);

        issue(0, 1, SZ8, 64'h10000, 64'h0);
        wait_sig(1, "wb_req");
        chk("wb_pa", pa, 64'h8000);
        chk("wb_no_rf", read_line_req, 0);
        bad = 0;
        for (int k = 0; k <= 256; k++) begin
            @(posedge clk); #1;
            if (k < 256) addr_count = 11'(k * 8);
            else         trans_rdy = 1'b1;
            @(negedge clk);
            if (k < 256 && sram_addr !== 12'(k)) bad++;
            if (sram_we !== 1'b0 || write_line_req !== 1'b1) bad++;
            if (k > 0 && wt_data !== exp_line[k-1]) bad++;
        end
        @(posedge clk); #1;
        trans_rdy = 1'b0;
        chk("wb_beats_bad", bad, 0);
        wait_sig(0, "rf2_req");
        chk("rf2_pa", pa, 64'h10000);
        chk("rf2_no_wb", write_line_req, 0);
        chk("wb_dirty_cleared", dut.u_tags.dirty_q[0], 0);
        refill(S2, -1, "rf2");
        expect_resp("rf2", beat(S2, 0));
        chk("rf2_clean", dut.u_tags.dirty_q[0], 0);

        issue(1, 0, SZ4, 64'hF000_0004, 64'h1122_3344_0000_0000);
        wait_sig(3, "wt_req");
        chk("wt_pa", pa, 64'hF000_0004);
        chk("wt_data", wt_data, 64'h1122_3344_0000_0000);
        chk("wt_size", size, SZ4);
        chk("wt_no_sram", sram_we, 0);
        chk("wt_others", {read_line_req, write_line_req, read_req}, 0);
        @(posedge clk); #1;
        trans_rdy = 1'b1;
        @(negedge clk);
        chk("wt_held", write_through_req, 1);
        chk("wt_no_early_resp", resp_valid, 0);
        @(posedge clk); #1;
        trans_rdy = 1'b0;
        @(negedge clk);
        chk("wt_resp", resp_valid, 1);
        chk("wt_resp_err", resp_err, 0);
        chk("wt_dropped", write_through_req, 0);

        issue(0, 0, SZ8, 64'hF000_0010, 64'h0);
        wait_sig(2, "ur_req");
        chk("ur_pa", pa, 64'hF000_0010);
        @(posedge clk); #1;
        trans_rdy = 1'b1; line_data = 64'hCAFE_F00D_1234_ABCD;
        @(posedge clk); #1;
        trans_rdy = 1'b0;
        @(negedge clk);
        chk("ur_resp", resp_valid, 1);
        chk("ur_rdata", resp_rdata, 64'hCAFE_F00D_1234_ABCD);

        issue(0, 1, SZ8, 64'h20000, 64'h0);
        wait_sig(0, "rf3_req");
        chk("rf3_pa", pa, 64'h20000);
        chk("rf3_no_wb", write_line_req, 0);
        refill(S3, 100, "rf3");
        @(negedge clk);
        chk("rf3_err_valid", resp_valid, 1);
        chk("rf3_err", resp_err, 1);
        chk("rf3_req_dropped", read_line_req, 0);
        chk("rf3_invalid", dut.u_tags.valid_q[0], 0);

        issue(0, 1, SZ8, 64'h20008, 64'h0);
        wait_sig(0, "rf4_req");
        chk("rf4_pa", pa, 64'h20000);
        refill(S4, -1, "rf4");
        expect_resp("rf4", beat(S4, 1));

        issue(0, 1, SZ8, 64'h8000, 64'h0);
        wait_sig(0, "rf5_req");
        @(posedge clk); #1;
        line_write = 1'b1; addr_count = 11'd0; line_data = beat(S1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        line_write = 1'b0;
        #1;
        chk("midrst_rf_req", read_line_req, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_sram_we", sram_we, 0);
        chk("midrst_valid", dut.u_tags.valid_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        chk("one_req_at_a_time", multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
